// File: rtl/bus_dir_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_dir_arbiter_if
// Bundles the request/grant/direction signals between the two bus masters and
// the direction arbiter that steers the A<->B exchange transceiver.
//
// Handshake: req_x is a level request and is held high for the whole
// transfer. gnt_x is the arbiter's answer and means "x owns the bus this
// cycle". drv_en is high exactly when one of the gnts is high. A master
// must tolerate losing gnt mid-transfer, because a long burst can be
// preempted. The arbiter never asserts both gnts in the same cycle.
//
// Signals
//   req_a, req_b : master -> arbiter, requests (A->B / B->A direction)
//   oe0          : arbiter -> bus, transceiver direction (0 = A->B, 1 = B->A)
//   drv_en       : arbiter -> bus, transceiver output enable (0 = both hi-Z)
//   gnt_a, gnt_b : arbiter -> masters, bus ownership
//   burst_cnt    : arbiter -> masters, 0-based grant cycles of current owner
//   state        : arbiter -> observers, debug view of the FSM state
// ---------------------------------------------------------------------------
interface bus_dir_arbiter_if #(
  parameter int CW = 5
);
  logic          req_a;
  logic          req_b;
  logic          oe0;
  logic          drv_en;
  logic          gnt_a;
  logic          gnt_b;
  logic [CW-1:0] burst_cnt;
  logic [1:0]    state;

  modport master (
    output req_a, req_b,
    input  oe0, drv_en, gnt_a, gnt_b, burst_cnt, state
  );

  modport slave (
    input  req_a, req_b,
    output oe0, drv_en, gnt_a, gnt_b, burst_cnt, state
  );
endinterface

// File: rtl/bus_dir_arbiter.sv
// ---------------------------------------------------------------------------
// bus_dir_arbiter
// Direction controller for the 16-bit A<->B exchange transceiver. Chooses
// which side owns the bus, drives the transceiver direction (oe0) and its
// output enable (drv_en), and inserts TURN_CYC dead cycles on every
// direction change so that the two buses never drive against each other.
// Long owners are preempted after MAX_BURST grant cycles if the other side
// is waiting.
//
// Ports
//   clk : clock; all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : bus_dir_arbiter_if.slave (requests in; oe0, drv_en, gnt_a,
//         gnt_b, burst_cnt and the debug state out, all registered)
// ---------------------------------------------------------------------------
module bus_dir_arbiter #(
  parameter int TURN_CYC  = 2,
  parameter int MAX_BURST = 16,
  parameter int CW        = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  bus_dir_arbiter_if.slave        bus
);

  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
  localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TURN  = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  state_t        r_state,     w_state_nxt;
  logic          r_oe0,       w_oe0_nxt;
  logic          r_drv_en,    w_drv_en_nxt;
  logic          r_gnt_a,     w_gnt_a_nxt;
  logic          r_gnt_b,     w_gnt_b_nxt;
  logic [CW-1:0] r_burst_cnt, w_burst_cnt_nxt;
  logic          r_last_b,    w_last_b_nxt;   // last owner was B
  logic          r_pend_b,    w_pend_b_nxt;   // side waiting out the TURN
  logic [TW-1:0] r_turn_cnt,  w_turn_cnt_nxt;

  logic w_any_req;
  logic w_win_b;
  logic w_own_req;
  logic w_oth_req;
  logic w_pend_req;

  // Round robin on a tie: the side that did not own the bus last wins.
  assign w_any_req  = bus.req_a | bus.req_b;
  assign w_win_b    = bus.req_b & (~bus.req_a | ~r_last_b);

  // In GRANT, gnt_b tells who the owner is.
  assign w_own_req  = r_gnt_b ? bus.req_b : bus.req_a;
  assign w_oth_req  = r_gnt_b ? bus.req_a : bus.req_b;
  assign w_pend_req = r_pend_b ? bus.req_b : bus.req_a;

  always_comb begin
    w_state_nxt     = r_state;
    w_oe0_nxt       = r_oe0;
    w_gnt_a_nxt     = 1'b0;
    w_gnt_b_nxt     = 1'b0;
    w_burst_cnt_nxt = '0;
    w_last_b_nxt    = r_last_b;
    w_pend_b_nxt    = r_pend_b;
    w_turn_cnt_nxt  = '0;

    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          if (w_win_b == r_oe0) begin
            // Already pointing the right way: grant straight away.
            w_state_nxt  = S_GRANT;
            w_gnt_a_nxt  = ~w_win_b;
            w_gnt_b_nxt  = w_win_b;
            w_last_b_nxt = w_win_b;
          end else begin
            // Flip direction now, with the drivers off for TURN_CYC cycles.
            w_state_nxt  = S_TURN;
            w_oe0_nxt    = w_win_b;
            w_pend_b_nxt = w_win_b;
          end
        end
      end

      S_TURN: begin
        if (r_turn_cnt == TURN_LAST) begin
          // Only the side we turned for is considered; anything that arrived
          // for the other side waits for the next IDLE evaluation.
          if (w_pend_req) begin
            w_state_nxt  = S_GRANT;
            w_gnt_a_nxt  = ~r_pend_b;
            w_gnt_b_nxt  = r_pend_b;
            w_last_b_nxt = r_pend_b;
          end else begin
            w_state_nxt  = S_IDLE;
          end
        end else begin
          w_turn_cnt_nxt = r_turn_cnt + 1'b1;
        end
      end

      S_GRANT: begin
        if (!w_own_req) begin
          w_state_nxt = S_IDLE;
        end else if ((r_burst_cnt == BURST_LAST) && w_oth_req) begin
          // Preempt the long owner and turn for the waiting side.
          w_state_nxt  = S_TURN;
          w_oe0_nxt    = ~r_gnt_b;
          w_pend_b_nxt = ~r_gnt_b;
        end else begin
          w_gnt_a_nxt     = r_gnt_a;
          w_gnt_b_nxt     = r_gnt_b;
          w_burst_cnt_nxt = (r_burst_cnt == BURST_LAST) ? r_burst_cnt
                                                        : r_burst_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_drv_en_nxt = w_gnt_a_nxt | w_gnt_b_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_oe0       <= 1'b0;
      r_drv_en    <= 1'b0;
      r_gnt_a     <= 1'b0;
      r_gnt_b     <= 1'b0;
      r_burst_cnt <= '0;
      r_last_b    <= 1'b1;
      r_pend_b    <= 1'b0;
      r_turn_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_oe0       <= w_oe0_nxt;
      r_drv_en    <= w_drv_en_nxt;
      r_gnt_a     <= w_gnt_a_nxt;
      r_gnt_b     <= w_gnt_b_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_last_b    <= w_last_b_nxt;
      r_pend_b    <= w_pend_b_nxt;
      r_turn_cnt  <= w_turn_cnt_nxt;
    end
  end

  assign bus.oe0       = r_oe0;
  assign bus.drv_en    = r_drv_en;
  assign bus.gnt_a     = r_gnt_a;
  assign bus.gnt_b     = r_gnt_b;
  assign bus.burst_cnt = r_burst_cnt;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_bus_dir_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_dir_arbiter
// Bench for bus_dir_arbiter (TURN_CYC=2, MAX_BURST=16, CW=5). Each step
// drives rst/req_a/req_b for one cycle and queues the outputs expected after
// the next rising edge, packed as {oe0, drv_en, gnt_a, gnt_b, burst_cnt}.
// ---------------------------------------------------------------------------
module tb_bus_dir_arbiter;

  localparam int CW = 5;
  localparam int EW = 4 + CW;

  typedef struct {
    logic          rst;
    logic          ra;
    logic          rb;
    logic [EW-1:0] exp;
    string         name;
  } vec_t;

  logic clk;
  logic rst;

  bus_dir_arbiter_if #(.CW(CW)) bus ();

  bus_dir_arbiter #(
    .TURN_CYC  (2),
    .MAX_BURST (16),
    .CW        (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  vec_t          vecs[$];
  int            total = 0;
  int            bad   = 0;
  logic          prev_oe0 = 1'b0;

  function automatic logic [EW-1:0] mk(input logic oe, input logic drv,
                                       input logic ga, input logic gb,
                                       input int bc);
    return {oe, drv, ga, gb, CW'(bc)};
  endfunction

  task automatic add(input logic r, input logic a, input logic b,
                     input logic [EW-1:0] e, input string n);
    vec_t v;
    v.rst = r; v.ra = a; v.rb = b; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  // scoreboard: pop the oldest expectation and compare with the DUT
  task automatic check(input string name);
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    got = {bus.oe0, bus.drv_en, bus.gnt_a, bus.gnt_b, bus.burst_cnt};
    e   = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s: got {oe0,drv_en,gnt_a,gnt_b,burst}=%b_%b_%b_%b_%0d exp=%b_%b_%b_%b_%0d",
               name, got[EW-1], got[EW-2], got[EW-3], got[EW-4], got[CW-1:0],
               e[EW-1], e[EW-2], e[EW-3], e[EW-4], e[CW-1:0]);
    end
    total++;
    if ((bus.drv_en !== (bus.gnt_a | bus.gnt_b)) || (bus.gnt_a & bus.gnt_b)) begin
      bad++;
      $display("FAIL %s_inv: drv_en=%b gnt_a=%b gnt_b=%b", name, bus.drv_en,
               bus.gnt_a, bus.gnt_b);
    end
    if (bus.oe0 !== prev_oe0) begin
      total++;
      if (bus.drv_en !== 1'b0) begin
        bad++;
        $display("FAIL %s_dead: oe0 changed with drv_en=%b, need 0", name, bus.drv_en);
      end
    end
    prev_oe0 = bus.oe0;
  endtask

  // driver: one cycle of stimulus, expectation queued for the next edge
  task automatic step(input logic r, input logic a, input logic b,
                      input logic [EW-1:0] e, input string name);
    rst       = r;
    bus.req_a = a;
    bus.req_b = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    rst       = 1'b1;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;

    // reset, A from reset with no turnaround, short drop of req_a
    add(1, 0, 0, mk(0, 0, 0, 0, 0), "reset");
    add(0, 1, 0, mk(0, 1, 1, 0, 0), "a_first");
    add(0, 1, 0, mk(0, 1, 1, 0, 1), "a_b1");
    add(0, 1, 0, mk(0, 1, 1, 0, 2), "a_b2");
    add(0, 0, 0, mk(0, 0, 0, 0, 0), "a_drop");
    add(0, 1, 0, mk(0, 1, 1, 0, 0), "a_regrant");
    add(0, 1, 0, mk(0, 1, 1, 0, 1), "a_regrant_b1");
    add(0, 0, 0, mk(0, 0, 0, 0, 0), "a_release");
    // B from reset: 2 dead cycles then grant
    add(1, 0, 0, mk(0, 0, 0, 0, 0), "reset2");
    add(0, 0, 1, mk(1, 0, 0, 0, 0), "b_turn1");
    add(0, 0, 1, mk(1, 0, 0, 0, 0), "b_turn2");
    add(0, 0, 1, mk(1, 1, 0, 1, 0), "b_grant");
    add(0, 0, 1, mk(1, 1, 0, 1, 1), "b_b1");
    add(0, 0, 1, mk(1, 1, 0, 1, 2), "b_b2");
    // reset mid-burst of B
    add(1, 0, 1, mk(0, 0, 0, 0, 0), "rst_mid");
    // B withdrawn during TURN, then A turns back
    add(0, 0, 1, mk(1, 0, 0, 0, 0), "w_turn1");
    add(0, 0, 0, mk(1, 0, 0, 0, 0), "w_turn2");
    add(0, 0, 0, mk(1, 0, 0, 0, 0), "w_idle");
    add(0, 0, 0, mk(1, 0, 0, 0, 0), "w_idle2");
    add(0, 1, 0, mk(0, 0, 0, 0, 0), "back_turn1");
    add(0, 1, 1, mk(0, 0, 0, 0, 0), "back_turn2");
    add(0, 1, 1, mk(0, 1, 1, 0, 0), "back_grant");
    add(0, 1, 1, mk(0, 1, 1, 0, 1), "back_b1");
    // owner drops while other waits: IDLE first, then normal select
    add(0, 0, 1, mk(0, 0, 0, 0, 0), "swap_idle");
    add(0, 0, 1, mk(1, 0, 0, 0, 0), "swap_turn1");
    add(0, 0, 0, mk(1, 0, 0, 0, 0), "swap_turn2");
    add(0, 0, 0, mk(1, 0, 0, 0, 0), "swap_none");
    // tie with oe0=1 and last owner A: B wins without turnaround
    add(0, 1, 1, mk(1, 1, 0, 1, 0), "tie_b");
    add(0, 0, 0, mk(1, 0, 0, 0, 0), "tie_rel");

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].ra, vecs[i].rb, vecs[i].exp, vecs[i].name);

    // both held from reset: 16 grant cycles, 2 dead, alternating owners
    step(1, 0, 0, mk(0, 0, 0, 0, 0), "rst_alt");
    for (int k = 1; k <= 60; k++) begin
      int side;
      int p;
      side = ((k - 1) / 18) % 2;
      p    = (k - 1) % 18;
      if (p < 16)
        step(0, 1, 1, mk(side[0], 1, !side[0], side[0], p), "alt_grant");
      else
        step(0, 1, 1, mk(!side[0], 0, 0, 0, 0), "alt_turn");
    end

    // lone owner saturates at 15, then gets preempted once B asks
    step(1, 0, 0, mk(0, 0, 0, 0, 0), "rst_sat");
    for (int k = 1; k <= 20; k++)
      step(0, 1, 0, mk(0, 1, 1, 0, (k - 1 > 15) ? 15 : k - 1), "sat");
    step(0, $urandom_range(1, 1), 1, mk(1, 0, 0, 0, 0), "preempt_t1");
    step(0, 1, 1, mk(1, 0, 0, 0, 0), "preempt_t2");
    step(0, 1, 1, mk(1, 1, 0, 1, 0), "preempt_gnt");

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue: %0d left, need 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
